// File: rtl/prng_pkg.sv
// Shared constants and helpers for the PRNG bank: LFSR taps per word width and the
// Galois step function used by every lane.
package prng_pkg;

  localparam logic [63:0] TAP_W16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAP_W32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAP_W64 = 64'hD800_0000_0000_0000;
  localparam int unsigned CNT_W   = 16;

  function automatic logic [63:0] tap_for(input int unsigned width);
    case (width)
      16:      return TAP_W16;
      32:      return TAP_W32;
      64:      return TAP_W64;
      default: return 64'd0;
    endcase
  endfunction

  // Galois right-shift step; callers pass the state zero-extended to 64 bits
  function automatic logic [63:0] next_state(input logic [63:0] s, input logic [63:0] tap);
    return (s >> 1) ^ (s[0] ? tap : 64'd0);
  endfunction

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_lane.sv
// One generator channel: LFSR state, draw counter, valid strobe and output word.
// Optional per-lane output mask when PRNG_MASK_EN is defined.
module prng_lane
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_SEED = '1,
  parameter logic [WIDTH-1:0] DEF_SEED = '1,
  parameter logic [WIDTH-1:0] TAP      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             seed_we_i,
  input  logic [WIDTH-1:0] seed_i,
`ifdef PRNG_MASK_EN
  input  logic             mask_we_i,
  input  logic [WIDTH-1:0] mask_i,
`endif
  output logic [WIDTH-1:0] rnd_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_rnd;

`ifdef PRNG_MASK_EN
  logic [WIDTH-1:0] r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_mask <= '1;
    else if (mask_we_i) r_mask <= mask_i;
  end
`endif

  // All-zero state would lock the LFSR, so a zero seed falls back to the default
  always_comb begin
    w_next = WIDTH'(next_state(64'(r_state), 64'(TAP)));
    w_seed = (seed_i == '0) ? DEF_SEED : seed_i;
`ifdef PRNG_MASK_EN
    w_rnd  = w_next & r_mask;
`else
    w_rnd  = w_next;
`endif
  end

  // Seed write has priority over a draw in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_SEED;
      rnd_o   <= '0;
      valid_o <= 1'b0;
      cnt_o   <= '0;
    end else begin
      valid_o <= 1'b0;
      if (seed_we_i) begin
        r_state <= w_seed;
        cnt_o   <= '0;
      end else if (req_i) begin
        r_state <= w_next;
        rnd_o   <= w_rnd;
        valid_o <= 1'b1;
        cnt_o   <= cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prng_bank.sv
// Bank of NUM_CH independent Galois-LFSR generators with per-channel seeding.
// Define PRNG_MASK_EN to add per-channel output masks (mask_we_i / mask_i).
module prng_bank
  import prng_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_ACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic                      seed_we_i,
  input  logic [sel_w(NUM_CH)-1:0]  seed_ch_i,
  input  logic [WIDTH-1:0]          seed_i,
`ifdef PRNG_MASK_EN
  input  logic                      mask_we_i,
  input  logic [WIDTH-1:0]          mask_i,
`endif
  output logic [NUM_CH*WIDTH-1:0]   rnd_o,
  output logic [NUM_CH-1:0]         valid_o,
  output logic [NUM_CH*CNT_W-1:0]   cnt_o
);

  localparam int unsigned      SEL_W = sel_w(NUM_CH);
  localparam logic [WIDTH-1:0] TAP   = WIDTH'(tap_for(WIDTH));
  localparam logic [WIDTH-1:0] DSEED = WIDTH'(DEFAULT_SEED);

  if (WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("prng_bank: WIDTH must be 16, 32 or 64");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("prng_bank: NUM_CH must be in 1..16");
  end

  logic [NUM_CH-1:0] w_sel;

  // Out-of-range channel selects match no lane and are dropped
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [WIDTH-1:0] XSEED = DSEED ^ WIDTH'(k);
    localparam logic [WIDTH-1:0] RSEED = (XSEED == '0) ? DSEED : XSEED;

    assign w_sel[k] = (seed_ch_i == SEL_W'(k));

    prng_lane #(
      .WIDTH    (WIDTH),
      .RST_SEED (RSEED),
      .DEF_SEED (DSEED),
      .TAP      (TAP)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i[k]),
      .seed_we_i (seed_we_i & w_sel[k]),
      .seed_i    (seed_i),
`ifdef PRNG_MASK_EN
      .mask_we_i (mask_we_i & w_sel[k]),
      .mask_i    (mask_i),
`endif
      .rnd_o     (rnd_o[k*WIDTH +: WIDTH]),
      .valid_o   (valid_o[k]),
      .cnt_o     (cnt_o[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_prng_bank.sv
// Directed self-checking bench for prng_bank (NUM_CH=4, WIDTH=16).
module tb_prng_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 16;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    req_i;
  logic              seed_we_i;
  logic [1:0]        seed_ch_i;
  logic [W-1:0]      seed_i;
`ifdef PRNG_MASK_EN
  logic              mask_we_i;
  logic [W-1:0]      mask_i;
`endif
  logic [NCH*W-1:0]  rnd_o;
  logic [NCH-1:0]    valid_o;
  logic [NCH*16-1:0] cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  prng_bank #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_SEED(32'h0000_ACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .seed_we_i (seed_we_i),
    .seed_ch_i (seed_ch_i),
    .seed_i    (seed_i),
`ifdef PRNG_MASK_EN
    .mask_we_i (mask_we_i),
    .mask_i    (mask_i),
`endif
    .rnd_o     (rnd_o),
    .valid_o   (valid_o),
    .cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd(input int k);
    return rnd_o[k*16 +: 16];
  endfunction

  function automatic logic [15:0] cnt(input int k);
    return cnt_o[k*16 +: 16];
  endfunction

  function automatic logic [15:0] lfsr16(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // One clock with the given request/seed inputs, then inputs return idle
  task automatic cyc(input logic [3:0] req, input logic we, input logic [1:0] ch,
                     input logic [15:0] sd);
    req_i = req; seed_we_i = we; seed_ch_i = ch; seed_i = sd;
    @(posedge clk); #1;
    req_i = '0; seed_we_i = 1'b0;
  endtask

  logic [15:0] stream [8];
  logic [15:0] post3 [3];
  logic [15:0] s3;

  initial begin
    stream = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680,
               16'h0B40, 16'h05A0, 16'h02D0, 16'h0168};
    post3  = '{16'hE270, 16'h7138, 16'h389C};
    rst_n = 1'b0; req_i = '0; seed_we_i = 1'b0; seed_ch_i = '0; seed_i = '0;
`ifdef PRNG_MASK_EN
    mask_we_i = 1'b0; mask_i = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_rnd", 64'(rnd_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    rst_n = 1'b1;

    // first edge after release: each lane steps from DEFAULT_SEED ^ k
    cyc(4'b1111, 1'b0, 2'd0, 16'h0);
    check("first_ch0", 64'(rnd(0)), 64'hE270);
    check("first_ch1", 64'(rnd(1)), 64'h5670);
    check("first_ch2", 64'(rnd(2)), 64'hE271);
    check("first_ch3", 64'(rnd(3)), 64'h5671);
    check("first_valid", 64'(valid_o), 64'hF);
    check("first_cnt0", 64'(cnt(0)), 64'd1);

    cyc(4'b0000, 1'b0, 2'd0, 16'h0);
    check("idle_valid", 64'(valid_o), 64'd0);
    check("idle_hold", 64'(rnd(0)), 64'hE270);

    cyc(4'b0000, 1'b1, 2'd0, 16'h0001);
    check("seed_valid", 64'(valid_o[0]), 64'd0);
    check("seed_cnt", 64'(cnt(0)), 64'd0);
    check("seed_rnd_hold", 64'(rnd(0)), 64'hE270);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, 1'b0, 2'd0, 16'h0);
      check($sformatf("seq1_rnd%0d", i), 64'(rnd(0)), 64'(stream[i]));
      check($sformatf("seq1_vld%0d", i), 64'(valid_o[0]), 64'd1);
    end
    check("seq1_cnt", 64'(cnt(0)), 64'd4);

    cyc(4'b0000, 1'b1, 2'd0, 16'h0000);
    cyc(4'b0001, 1'b0, 2'd0, 16'h0);
    check("zero_seed", 64'(rnd(0)), 64'hE270);

    cyc(4'b0010, 1'b1, 2'd1, 16'h0001);
    check("coll_valid", 64'(valid_o[1]), 64'd0);
    check("coll_cnt", 64'(cnt(1)), 64'd0);
    check("coll_rnd", 64'(rnd(1)), 64'h5670);
    cyc(4'b0010, 1'b0, 2'd0, 16'h0);
    check("coll_next", 64'(rnd(1)), 64'hB400);
    check("coll_cnt1", 64'(cnt(1)), 64'd1);

    // channel 2 reseeded twice; channel 3 runs alongside the second stream
    cyc(4'b0000, 1'b1, 2'd2, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0100, 1'b0, 2'd0, 16'h0);
      check($sformatf("ch2a_%0d", i), 64'(rnd(2)), 64'(stream[i]));
    end
    check("ch3_idle", 64'(rnd(3)), 64'h5671);
    cyc(4'b0000, 1'b1, 2'd2, 16'h0001);
    s3 = 16'h5671;
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1100, 1'b0, 2'd0, 16'h0);
      s3 = lfsr16(s3);
      check($sformatf("ch2b_%0d", i), 64'(rnd(2)), 64'(stream[i]));
      check($sformatf("ch3_%0d", i), 64'(rnd(3)), 64'(s3));
    end
    check("ch3_cnt", 64'(cnt(3)), 64'd9);

    // asynchronous reset mid-stream, then replay
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        cyc(4'b0001, 1'b0, 2'd0, 16'h0);
        check($sformatf("rst_p%0d_%0d", pass, i), 64'(rnd(0)), 64'(post3[i]));
      end
      if (pass == 0) begin
        #2; rst_n = 1'b0; #1;
        check("async_rnd", 64'(rnd_o), 64'd0);
        check("async_valid", 64'(valid_o), 64'd0);
        check("async_cnt", 64'(cnt_o), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
      end
    end

    // draw counter wraps from FFFF to 0
    req_i = 4'b1000;
    repeat (65535) @(posedge clk);
    #1;
    check("cnt_ffff", 64'(cnt(3)), 64'hFFFF);
    @(posedge clk); #1;
    req_i = '0;
    check("cnt_wrap", 64'(cnt(3)), 64'd0);
    check("cnt_wrap_vld", 64'(valid_o[3]), 64'd1);

`ifdef PRNG_MASK_EN
    mask_we_i = 1'b1; mask_i = 16'h000F;
    cyc(4'b0000, 1'b1, 2'd0, 16'h0001);
    mask_we_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, 1'b0, 2'd0, 16'h0);
      check($sformatf("mask_%0d", i), 64'(rnd(0)), 64'(stream[i] & 16'h000F));
    end
    mask_we_i = 1'b1; mask_i = 16'hFFFF; seed_ch_i = 2'd0;
    @(posedge clk); #1;
    mask_we_i = 1'b0;
    cyc(4'b0001, 1'b0, 2'd0, 16'h0);
    check("mask_state", 64'(rnd(0)), 64'(stream[4]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prng_bank.md
PRNG_BANK -- requirements
Module: prng_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent generator channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the generator word width; legal values are 16, 32 and 64, and any other value is an elaboration error.
REQ-003 SHALL have parameter DEFAULT_SEED, default 32'h0000_ACE1, meaning the base reset seed; it is zero-extended or truncated to WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_i, input, NUM_CH bits: per-channel draw request, sampled every cycle.
REQ-007 SHALL have port seed_we_i, input, 1 bit: seed write strobe.
REQ-008 SHALL have port seed_ch_i, input, $clog2(NUM_CH) bits (minimum 1): the channel selected for the seed write.
REQ-009 SHALL have port seed_i, input, WIDTH bits: the seed value.
REQ-010 SHALL have port rnd_o, output, NUM_CH*WIDTH bits: per-channel random word, with channel k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port valid_o, output, NUM_CH bits: per-channel one-cycle valid strobe.
REQ-012 SHALL have port cnt_o, output, NUM_CH*16 bits: per-channel draw count since the last seed.

Function
REQ-013 Each channel SHALL hold a WIDTH-bit state register and advance it with a Galois right-shift LFSR: next = (s>>1) ^ (s[0] ? TAP : 0).
REQ-014 TAP SHALL be 16'hB400 for WIDTH 16, 32'h8020_0003 for WIDTH 32, and 64'hD800_0000_0000_0000 for WIDTH 64.
REQ-015 When req_i[k]=1 in cycle t, the state SHALL advance once, and rnd_o[k] SHALL show the advanced state with valid_o[k]=1 in cycle t+1, giving a latency of 1 cycle.
REQ-016 When req_i[k]=0, the state SHALL hold, valid_o[k] SHALL be 0, and rnd_o[k] SHALL hold its last value.
REQ-017 Back-to-back requests SHALL yield one new word per cycle with no bubbles.
REQ-018 Channels SHALL be fully independent; a request or seed on one channel SHALL NOT alter any other channel.
REQ-019 A seed write (seed_we_i=1) SHALL load seed_i into the state of channel seed_ch_i at the next edge.
REQ-020 A seed write SHALL clear cnt_o of that channel to 0.
REQ-021 A seed write SHALL force valid_o of that channel to 0 for that cycle.
REQ-022 A seed write SHALL leave rnd_o of that channel unchanged.
REQ-023 A zero seed_i SHALL be replaced by DEFAULT_SEED, because the all-zero state locks the LFSR.
REQ-024 When a seed write and req_i target the same channel in the same cycle, the seed SHALL win: no advance, and valid_o=0.
REQ-025 A seed_ch_i value >= NUM_CH SHALL be ignored, with no state change.
REQ-026 cnt_o[k] SHALL increment on every accepted draw and wrap from 16'hFFFF to 0.

Reset
REQ-027 While rst_n=0, the state of channel k SHALL be DEFAULT_SEED ^ k; if that value is zero it SHALL be DEFAULT_SEED instead.
REQ-028 While rst_n=0, rnd_o SHALL be 0, valid_o SHALL be 0 and cnt_o SHALL be 0.
REQ-029 Reset asserted mid-stream SHALL clear every output immediately (asynchronously) and restart each sequence from its reset seed.
REQ-030 The first request after reset release SHALL be honoured on the first rising edge.

Configuration
REQ-031 With macro PRNG_MASK_EN defined, the block SHALL add input mask_we_i (1 bit) and input mask_i (WIDTH bits), written to the mask of channel seed_ch_i.
REQ-032 With PRNG_MASK_EN defined, rnd_o[k] SHALL equal state & mask[k], and the masks SHALL reset to all ones.
REQ-033 With PRNG_MASK_EN defined, the mask SHALL NOT affect state advance.
REQ-034 Without PRNG_MASK_EN, the mask ports SHALL be absent and rnd_o SHALL be the raw state.

Structure
REQ-035 Package prng_pkg SHALL hold the TAP constants per width, a function tap_for(width), and a function next_state(s, tap).
REQ-036 The design SHALL use sub-module prng_lane (one channel: state, count, valid and mask), instantiated NUM_CH times by a generate loop.

Verification
REQ-037 With WIDTH=16, a seed of 16'h0001 on channel 0 followed by 4 requests SHALL give rnd_o = B400, 5A00, 2D00, 1680, with valid_o[0]=1 on each, and cnt_o[0]=4.
REQ-038 Writing seed 0 SHALL make the next draw equal next_state(DEFAULT_SEED).
REQ-039 A simultaneous seed and request on channel 1 SHALL give valid_o[1]=0 and cnt_o[1]=0, and the following draw SHALL equal next_state(seed).
REQ-040 Reseeding channel 2 with the same value twice SHALL make two identical 8-word streams, while channel 3 continues undisturbed.
REQ-041 Reset asserted after 3 draws SHALL clear outputs immediately, and the post-reset stream SHALL equal the first post-reset stream.
REQ-042 With PRNG_MASK_EN defined and mask=16'h000F, all rnd_o SHALL be <= 15, and the unmasked state sequence SHALL be unchanged.
